// File: rtl/rk_window_controller.sv
// rk_window_controller: sequences start/load/sum/cumulative enables of a box-filter datapath over a COLS x ROWS frame
module rk_window_controller #(
  parameter int COLS      = 19,
  parameter int ROWS      = 19,
  parameter int RADIUS    = 8,
  parameter int START_LAT = 4,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done_i,
  input  logic          valid_i,
  input  logic          abort_i,
  output logic          start_en,
  output logic          ld_en,
  output logic          count_en,
  output logic          sum_en,
  output logic          cum_en,
  output logic          done_o,
  output logic          progress_done,
  output logic          busy,
  output logic [CW-1:0] col_o,
  output logic [CW-1:0] row_o
);
  typedef enum logic [2:0] {IDLE, START, START_ROW, SUM_EN, CUM_EN, FINISH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d, scnt_q, scnt_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      scnt_q  <= scnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    scnt_d  = scnt_q;
    if (abort_i) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      scnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (done_i) begin
          state_d = START;
          row_d   = '0;
          scnt_d  = '0;
        end
        START: if (valid_i) begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == CW'(START_LAT - 1)) state_d = START_ROW;
        end
        START_ROW: begin
          col_d   = '0;
          state_d = SUM_EN;
        end
        SUM_EN: if (valid_i) begin
          col_d = col_q + 1'b1;
          if (col_q == CW'(2 * RADIUS - 1)) state_d = CUM_EN;
        end
        CUM_EN: if (valid_i) begin
          // the row's last column holds col so it never exceeds COLS-1
          if (col_q != CW'(COLS - 1)) col_d = col_q + 1'b1;
          else if (row_q == CW'(ROWS - 1)) state_d = FINISH;
          else begin
            row_d   = row_q + 1'b1;
            state_d = START_ROW;
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  assign start_en      = state_q == START;
  assign ld_en         = state_q == START_ROW;
  assign count_en      = state_q == START_ROW || state_q == SUM_EN || state_q == CUM_EN;
  assign sum_en        = state_q == SUM_EN && valid_i;
  assign cum_en        = state_q == CUM_EN && valid_i;
  assign done_o        = cum_en;
  assign progress_done = state_q == FINISH;
  assign busy          = state_q != IDLE;
  assign col_o         = col_q;
  assign row_o         = row_q;
endmodule

// File: doc/rk_window_controller.md
Name: rk_window_controller

Overview:
- Parametrised successor to the fixed R8 row/window controller: sequences the sum, cumulative and load enables for a (2*RADIUS)-wide box-filter datapath over a COLS x ROWS frame.
- Owns its column, row and start-latency counters; the external counter, start and row-max inputs are gone.
- Adds a pixel-valid stall (valid_i), a synchronous abort, and automatic return to IDLE after a frame, so back-to-back frames work.
- Sits between the line-buffer front end (done_i) and the sum/cumulative datapath.

Parameters:
- COLS, 19, pixels per row; must satisfy COLS > 2*RADIUS.
- ROWS, 19, rows per frame; ROWS >= 1.
- RADIUS, 8, window radius; the SUM phase covers 2*RADIUS valid columns.
- START_LAT, 4, valid cycles spent in START before the first row.
- CW, 10, width of the col/row counters and outputs; 2^CW > max(COLS, ROWS).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low: everything clears while rst=0.
- done_i  input  1  upstream line buffer primed; frame start request.
- valid_i  input  1  pixel valid this cycle; 0 stalls counting.
- abort_i  input  1  synchronous abort, any state.
- start_en  output  1  high in START.
- ld_en  output  1  one-cycle row load, high in START_ROW.
- count_en  output  1  high in START_ROW, SUM_EN, CUM_EN.
- sum_en  output  1  SUM_EN & valid_i.
- cum_en  output  1  CUM_EN & valid_i.
- done_o  output  1  output pixel valid: CUM_EN & valid_i.
- progress_done  output  1  one-cycle frame-complete pulse.
- busy  output  1  state != IDLE.
- col_o  output  CW  column counter.
- row_o  output  CW  row counter.

Behaviour:
- Reset (rst=0): state=IDLE; start_cnt, col, row = 0; all outputs 0.
- Outputs are decoded combinationally from the state register plus valid_i.
  - Every output has a defined value in every state; no latches.
  - Any output not listed as high in a state is 0.
- States: IDLE, START, START_ROW, SUM_EN, CUM_EN, FINISH.
- Priority within a cycle: rst, then abort_i, then the transitions below.
- abort_i=1 in any state:
  - next state IDLE; counters cleared.
  - No progress_done pulse.
  - Outputs for that cycle still follow the current state.
- IDLE:
  - done_i=1: go to START, row<=0, start_cnt<=0.
  - done_i is ignored in every other state.
- START:
  - start_cnt increments on valid_i.
  - When valid_i=1 and start_cnt==START_LAT-1: go to START_ROW.
  - With valid_i held high, START lasts exactly START_LAT cycles.
- START_ROW:
  - Always one cycle; col<=0; go to SUM_EN.
  - valid_i is not sampled in this state.
- SUM_EN:
  - col increments on valid_i.
  - When valid_i=1 and col==2*RADIUS-1: go to CUM_EN.
- CUM_EN:
  - col increments on valid_i.
  - When valid_i=1 and col==COLS-1:
    - if row==ROWS-1, go to FINISH;
    - else row<=row+1 and go to START_ROW.
- FINISH: progress_done=1 for one cycle; go to IDLE.
- valid_i=0 in START, SUM_EN or CUM_EN holds state and counters, and gates sum_en/cum_en/done_o low.
- Per row, with no stalls:
  - 1 START_ROW cycle, 2*RADIUS SUM cycles, COLS-2*RADIUS CUM cycles.
  - done_o pulses COLS-2*RADIUS times per row.
- Counters never wrap: col is at most COLS-1 and row at most ROWS-1.
- Latency: done_i to start_en is 1 cycle; the last CUM cycle to progress_done is 1 cycle.
- Back-to-back frames: done_i accepted in the IDLE cycle after FINISH starts the next frame.

Test Plan:
- Nominal frame (COLS=19, RADIUS=8, ROWS=3, START_LAT=4, valid_i=1, done_i pulse at cycle 0):
  - start_en cycles 1-4; ld_en at 5, 25, 45.
  - sum_en 6-21; done_o 22-24 per row, 9 pulses total.
  - progress_done at 65; busy=0 at 66.
- Stall: drop valid_i for 3 cycles at SUM col=5 -> col holds 5, sum_en=0 during the stall; the row ends 3 cycles late with the same done_o count.
- Abort: abort_i at cycle 30 (row 1, SUM) -> IDLE at 31; col_o=row_o=0; no progress_done; a new done_i restarts a full frame.
- Async reset: drive rst=0 mid-CUM, between clock edges -> outputs and counters read 0 immediately; IDLE after release.
- Back-to-back: done_i in the cycle after FINISH -> start_en next cycle; second frame identical to the first.
- Ignore and edge: done_i during SUM has no effect. With ROWS=1 and COLS=17: one row, a single done_o pulse, then FINISH.
